// File: rtl/decode_buffer.sv
// Buffered RV32I decoder: DEPTH-entry {pc, instr} FIFO feeding a registered control-word stage.
// Optional DECODE_PERF_EN adds decoded_count / illegal_count handshake counters.
module decode_buffer #(
    parameter int DEPTH    = 4,
    parameter int PC_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [31:0]             in_instr,
    input  logic [PC_WIDTH-1:0]     in_pc,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [PC_WIDTH-1:0]     out_pc,
    output logic [31:0]             out_instr,
    output logic [6:0]              out_opcode,
    output logic [2:0]              out_aluop,
    output logic [1:0]              out_alumux1_sel,
    output logic [2:0]              out_alumux2_sel,
    output logic [1:0]              out_regfilemux_sel,
    output logic                    out_load_regfile,
    output logic                    out_mem_read,
    output logic                    out_mem_write,
    output logic [3:0]              out_mem_byte_enable,
    output logic [2:0]              out_mdr_sel,
    output logic [1:0]              out_pcmux_sel,
    output logic [2:0]              out_cmp_op,
    output logic                    out_illegal,
    output logic [$clog2(DEPTH):0]  count
`ifdef DECODE_PERF_EN
    ,
    output logic [31:0]             decoded_count,
    output logic [15:0]             illegal_count
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [2:0] aluop;
        logic [1:0] m1;
        logic [2:0] m2;
        logic [1:0] rf;
        logic       ld;
        logic       rd;
        logic       wr;
        logic [3:0] be;
        logic [2:0] mdr;
        logic [1:0] pcs;
        logic [2:0] cmp;
    } ctrl_t;

    logic [31:0]         mem_instr [DEPTH];
    logic [PC_WIDTH-1:0] mem_pc    [DEPTH];
    logic [AW-1:0]       wptr, rptr;
    logic                push, pop, dill;
    logic [31:0]         hinstr;
    logic [2:0]          f3;
    logic [6:0]          f7;
    ctrl_t               dc, oc;

    // in_ready depends only on registered occupancy, never on out_ready
    assign in_ready = (count < FULL);
    assign push     = in_valid && in_ready && !flush;
    assign pop      = (count != '0) && (!out_valid || out_ready) && !flush;
    assign hinstr   = mem_instr[rptr];
    assign f3       = hinstr[14:12];
    assign f7       = hinstr[31:25];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr[wptr] <= in_instr;
            mem_pc[wptr]    <= in_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        dc    = '0;
        dc.be = 4'b1111;
        dill  = 1'b0;
        case (hinstr[6:0])
            7'b0110111: begin dc.m1 = 2'b10; dc.m2 = 3'b001; dc.rf = 2'b10; dc.ld = 1'b1; end
            7'b0010111: begin dc.m1 = 2'b01; dc.m2 = 3'b001; dc.rf = 2'b10; dc.ld = 1'b1; end
            7'b1101111: begin
                dc.m1 = 2'b01; dc.m2 = 3'b100; dc.pcs = 2'b10; dc.rf = 2'b11; dc.ld = 1'b1;
            end
            7'b1100111: begin
                dc.pcs = 2'b10; dc.rf = 2'b11; dc.ld = 1'b1;
                dill   = (f3 != 3'b000);
            end
            7'b1100011: begin
                dc.m1 = 2'b01; dc.m2 = 3'b010; dc.pcs = 2'b01; dc.cmp = f3;
                dill  = (f3 == 3'b010) || (f3 == 3'b011);
            end
            7'b0000011: begin
                dc.rd = 1'b1; dc.ld = 1'b1;
                case (f3)
                    3'b000:  dc.mdr = 3'b011;
                    3'b001:  dc.mdr = 3'b001;
                    3'b010:  dc.mdr = 3'b000;
                    3'b100:  dc.mdr = 3'b100;
                    3'b101:  dc.mdr = 3'b010;
                    default: dill = 1'b1;
                endcase
            end
            7'b0100011: begin
                dc.m2 = 3'b011; dc.wr = 1'b1;
                case (f3)
                    3'b000:  dc.be = 4'b0001;
                    3'b001:  dc.be = 4'b0011;
                    3'b010:  dc.be = 4'b1111;
                    default: dill = 1'b1;
                endcase
            end
            7'b0010011: begin
                dc.aluop = f3; dc.rf = 2'b10; dc.ld = 1'b1;
                case (f3)
                    3'b010:  begin dc.aluop = 3'b000; dc.cmp = 3'b100; dc.rf = 2'b01; end
                    3'b011:  begin dc.aluop = 3'b000; dc.cmp = 3'b110; dc.rf = 2'b01; end
                    3'b001:  dill = (f7 != 7'b0000000);
                    3'b101: begin
                        dill = (f7 != 7'b0000000) && (f7 != 7'b0100000);
                        if (f7[5]) dc.aluop = 3'b010;
                    end
                    default: ;
                endcase
            end
            7'b0110011: begin
                dc.m2 = 3'b101; dc.aluop = f3; dc.rf = 2'b10; dc.ld = 1'b1;
                dill  = !((f7 == 7'b0000000) ||
                          (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)));
                case (f3)
                    3'b000:  if (f7[5]) dc.aluop = 3'b011;
                    3'b101:  if (f7[5]) dc.aluop = 3'b010;
                    3'b010:  begin dc.aluop = 3'b000; dc.cmp = 3'b100; dc.rf = 2'b01; end
                    3'b011:  begin dc.aluop = 3'b000; dc.cmp = 3'b110; dc.rf = 2'b01; end
                    default: ;
                endcase
            end
            default: dill = 1'b1;
        endcase
        // illegal words travel with pc/instr intact but carry no control
        if (dill) dc = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_pc      <= '0;
            out_instr   <= '0;
            out_illegal <= 1'b0;
            oc          <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (pop) begin
            out_valid   <= 1'b1;
            out_pc      <= mem_pc[rptr];
            out_instr   <= hinstr;
            out_illegal <= dill;
            oc          <= dc;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign out_opcode          = out_instr[6:0];
    assign out_aluop           = oc.aluop;
    assign out_alumux1_sel     = oc.m1;
    assign out_alumux2_sel     = oc.m2;
    assign out_regfilemux_sel  = oc.rf;
    assign out_load_regfile    = oc.ld;
    assign out_mem_read        = oc.rd;
    assign out_mem_write       = oc.wr;
    assign out_mem_byte_enable = oc.be;
    assign out_mdr_sel         = oc.mdr;
    assign out_pcmux_sel       = oc.pcs;
    assign out_cmp_op          = oc.cmp;

`ifdef DECODE_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            decoded_count <= '0;
            illegal_count <= '0;
        end else if (out_valid && out_ready) begin
            decoded_count <= decoded_count + 1'b1;
            if (out_illegal && illegal_count != 16'hFFFF)
                illegal_count <= illegal_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_decode_buffer.sv
// Scoreboard bench for decode_buffer: spec-level decode model, queue of expected words, negedge monitor.
module tb_decode_buffer;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [6:0]  opcode;
        logic [2:0]  aluop;
        logic [1:0]  m1;
        logic [2:0]  m2;
        logic [1:0]  rf;
        logic        ld;
        logic        rd;
        logic        wr;
        logic [3:0]  be;
        logic [2:0]  mdr;
        logic [1:0]  pcs;
        logic [2:0]  cmp;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0, rst, in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, out_pc, out_instr;
    logic [6:0]  out_opcode;
    logic [2:0]  out_aluop, out_alumux2_sel, out_mdr_sel, out_cmp_op;
    logic [1:0]  out_alumux1_sel, out_regfilemux_sel, out_pcmux_sel;
    logic        out_load_regfile, out_mem_read, out_mem_write, out_illegal;
    logic [3:0]  out_mem_byte_enable;
    logic [2:0]  count;
`ifdef DECODE_PERF_EN
    logic [31:0] decoded_count;
    logic [15:0] illegal_count;
`endif

    int   checks = 0, errors = 0, hs_total = 0, ill_total = 0;
    exp_t q[$];
    exp_t held;
    bit   hold_pend = 0;
    logic [2:0] mdr_tab [8] = '{3'd3, 3'd1, 3'd0, 3'd0, 3'd4, 3'd2, 3'd0, 3'd0};
    logic [6:0] ops [9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};

    decode_buffer #(.DEPTH(DEPTH), .PC_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_instr(out_instr), .out_opcode(out_opcode), .out_aluop(out_aluop),
        .out_alumux1_sel(out_alumux1_sel), .out_alumux2_sel(out_alumux2_sel),
        .out_regfilemux_sel(out_regfilemux_sel), .out_load_regfile(out_load_regfile),
        .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
        .out_mem_byte_enable(out_mem_byte_enable), .out_mdr_sel(out_mdr_sel),
        .out_pcmux_sel(out_pcmux_sel), .out_cmp_op(out_cmp_op),
        .out_illegal(out_illegal), .count(count)
`ifdef DECODE_PERF_EN
        , .decoded_count(decoded_count), .illegal_count(illegal_count)
`endif
    );

    always #5 clk = ~clk;

    // Expected decode straight from the instruction-class rules
    function automatic exp_t model(input logic [31:0] pc, input logic [31:0] ins);
        exp_t e;
        logic [2:0] f3;
        logic [6:0] f7;
        bit bad, isreg;
        f3 = ins[14:12]; f7 = ins[31:25]; bad = 0; isreg = ins[5];
        e = '0; e.be = 4'hF;
        case (ins[6:0])
            7'h37: begin e.m1 = 2; e.m2 = 1; e.rf = 2; e.ld = 1; end
            7'h17: begin e.m1 = 1; e.m2 = 1; e.rf = 2; e.ld = 1; end
            7'h6F: begin e.m1 = 1; e.m2 = 4; e.pcs = 2; e.rf = 3; e.ld = 1; end
            7'h67: begin e.pcs = 2; e.rf = 3; e.ld = 1; bad = (f3 != 0); end
            7'h63: begin e.m1 = 1; e.m2 = 2; e.pcs = 1; e.cmp = f3; bad = (f3 == 2 || f3 == 3); end
            7'h03: begin e.rd = 1; e.ld = 1; e.mdr = mdr_tab[f3]; bad = (f3 == 3 || f3 >= 6); end
            7'h23: begin
                e.m2 = 3; e.wr = 1; bad = (f3 > 2);
                e.be = (f3 == 0) ? 4'h1 : (f3 == 1) ? 4'h3 : 4'hF;
            end
            7'h13, 7'h33: begin
                e.rf = 2; e.ld = 1; e.m2 = isreg ? 3'd5 : 3'd0;
                if (f3 == 2 || f3 == 3) begin
                    e.aluop = 0; e.cmp = (f3 == 2) ? 3'd4 : 3'd6; e.rf = 1;
                end else if (f3 == 0) e.aluop = (isreg && f7[5]) ? 3'd3 : 3'd0;
                else if (f3 == 5) e.aluop = f7[5] ? 3'd2 : 3'd5;
                else e.aluop = f3;
                if (isreg) bad = !(f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)));
                else if (f3 == 1) bad = (f7 != 0);
                else if (f3 == 5) bad = !(f7 == 0 || f7 == 7'h20);
            end
            default: bad = 1;
        endcase
        if (bad) begin e = '0; e.ill = 1; end
        e.pc = pc; e.instr = ins; e.opcode = ins[6:0];
        return e;
    endfunction

    function automatic exp_t actual();
        return '{out_pc, out_instr, out_opcode, out_aluop, out_alumux1_sel, out_alumux2_sel,
                 out_regfilemux_sel, out_load_regfile, out_mem_read, out_mem_write,
                 out_mem_byte_enable, out_mdr_sel, out_pcmux_sel, out_cmp_op, out_illegal};
    endfunction

    task automatic check(input string nm, input logic [127:0] a, input logic [127:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, a, e, $time);
        end
    endtask

    // Monitor: scoreboard compare, hold stability, occupancy rules, then model update
    always @(negedge clk) begin
        exp_t act;
        if (rst) begin
            q.delete(); hold_pend = 0; hs_total = 0; ill_total = 0;
        end else begin
            act = actual();
            check("count_occupancy", 128'(count), 128'(q.size() - int'(out_valid)));
            check("in_ready_rule", 128'(in_ready), 128'(count < DEPTH));
            if (hold_pend) begin
                check("hold_valid", 128'(out_valid), 128'(1));
                check("hold_fields", act, held);
            end
            hold_pend = out_valid && !out_ready && !flush;
            held = act;
            if (out_valid && out_ready) begin
                hs_total++;
                if (out_illegal) ill_total++;
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_output actual=%0h expected=none at %0t", act, $time);
                end else check("decode_word", act, q.pop_front());
            end
            if (flush) q.delete();
            else if (in_valid && in_ready) q.push_back(model(in_pc, in_instr));
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic push(input logic [31:0] ins, input logic [31:0] pc);
        bit ok;
        int n;
        n = 0;
        in_valid = 1; in_instr = ins; in_pc = pc;
        do begin ok = in_ready; @(posedge clk); #1; n++; end while (!ok && n < 50);
        if (!ok) check("push_timeout", 0, 1);
    endtask

    function automatic logic [31:0] gen();
        logic [31:0] ins;
        int k;
        ins = $urandom;
        k = $urandom_range(0, 9);
        if (k > 0) begin
            ins[6:0] = ops[k-1];
            case ($urandom_range(0, 3))
                0: ins[31:25] = 7'h00;
                1: ins[31:25] = 7'h20;
                default: ;
            endcase
        end
        return ins;
    endfunction

    initial begin
        int n;
        rst = 1; in_valid = 0; in_instr = 0; in_pc = 0; flush = 0; out_ready = 0;
        #1;
        check("reset_fields", actual(), 0);
        check("reset_valid", 128'(out_valid), 0);
        check("reset_count", 128'(count), 0);
        cyc(2);
        rst = 0; #1;
        check("ready_after_reset", 128'(in_ready), 1);

        // addi x1,x0,10 : one-cycle latency into an empty buffer
        out_ready = 1;
        push(32'h00A00093, 32'h60);
        in_valid = 0;
        cyc(1);
        check("addi_valid", 128'(out_valid), 1);
        check("addi_pc", 128'(out_pc), 128'h60);
        check("addi_ctrl", 128'({out_aluop, out_regfilemux_sel, out_load_regfile, out_illegal}),
              128'({3'b000, 2'b10, 1'b1, 1'b0}));
        cyc(2);

        // backpressure: DEPTH+1 entries fit (FIFO + output stage)
        out_ready = 0;
        for (int i = 0; i < DEPTH + 1; i++) push(32'h00100093 + (i << 20), 32'h100 + 4 * i);
        in_valid = 0;
        check("full_count", 128'(count), 128'(DEPTH));
        check("full_ready", 128'(in_ready), 0);
        check("full_outvalid", 128'(out_valid), 1);
        in_valid = 1; in_instr = 32'h00700093; in_pc = 32'hBAD;
        cyc(2);
        in_valid = 0;
        out_ready = 1;
        n = hs_total;
        cyc(DEPTH + 1);
        check("drain_rate", 128'(hs_total - n), 128'(DEPTH + 1));
        check("drain_empty", 128'(out_valid), 0);

        // sub / sra / lw / sb, then illegal words
        push(32'h40B50533, 32'h200); push(32'h40B55533, 32'h204);
        push(32'h0000A503, 32'h208); push(32'h00B50023, 32'h20C);
        push(32'h00000000, 32'h210); push(32'h0000B003, 32'h214); push(32'h02B50533, 32'h218);
        in_valid = 0;
        cyc(4);

        // flush with a simultaneous push
        out_ready = 0;
        for (int i = 0; i < 3; i++) push(32'h00200113, 32'h300 + 4 * i);
        in_instr = 32'h00300193; in_pc = 32'h3F0; flush = 1;
        cyc(1);
        flush = 0; in_valid = 0;
        check("flush_valid", 128'(out_valid), 0);
        check("flush_count", 128'(count), 0);
        out_ready = 1;
        cyc(3);
        check("flush_nothing_out", 128'(out_valid), 0);

        // randomized traffic with occasional flush
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_instr  = gen();
            in_pc     = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            cyc(1);
        end
        in_valid = 0; flush = 0; out_ready = 1;
        n = 0;
        while (q.size() != 0 && n < 20) begin cyc(1); n++; end
        check("random_drained", 128'(q.size()), 0);

        // asynchronous reset mid-stream
        out_ready = 0;
        push(32'h00A00093, 32'h400); push(32'h0000B003, 32'h404);
        in_valid = 0;
        cyc(1);
        check("pre_rst_valid", 128'(out_valid), 1);
`ifdef DECODE_PERF_EN
        check("perf_decoded", 128'(decoded_count), 128'(hs_total));
        check("perf_illegal", 128'(illegal_count), 128'(ill_total));
`endif
        #3 rst = 1;
        #1;
        check("async_rst_valid", 128'(out_valid), 0);
        check("async_rst_fields", actual(), 0);
        check("async_rst_count", 128'(count), 0);
`ifdef DECODE_PERF_EN
        check("perf_rst", 128'({decoded_count, illegal_count}), 0);
`endif
        @(negedge clk);
        @(posedge clk); #1 rst = 0;
        #1 check("ready_after_rst2", 128'(in_ready), 1);
        out_ready = 1;
        push(32'h00A00093, 32'h60);
        in_valid = 0;
        cyc(3);
        check("post_rst_drained", 128'(q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
